// File: rtl/count_enable_gen.sv
// Enable source for the 8-bit up counter: synchronises and debounces the run/step buttons
// and issues a rate-controlled single-cycle enable strobe from a STOPPED/RUNNING machine.
module count_enable_gen #(
  parameter int DIV_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic [DIV_W-1:0] div_i,
  output logic             enable,
  output logic             running
);

  localparam int CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  logic [1:0]             btn_raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [CNT_W-1:0]       cnt_d  [2];
  logic [1:0]             synced;
  logic [1:0]             deb_q, deb_d;
  logic [1:0]             deb_dly_q, deb_dly_d;
  logic [1:0]             press;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       pcnt_q, pcnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   enable_q, enable_d;
  logic                   running_q, running_d;

  assign btn_raw = {step_btn, run_btn};

  // A debounced level only flips after DEBOUNCE_CYC consecutive disagreeing synced samples;
  // any agreeing sample restarts the count, so bounce shorter than that never gets through.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      synced[i] = sync_q[i][SYNC_STAGES-1];
      cnt_d[i]  = cnt_q[i];
      deb_d[i]  = deb_q[i];
      if (synced[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
        deb_d[i] = synced[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    deb_dly_d = deb_q;
  end

  // Rising edges of the debounced levels only; releasing a button does nothing.
  assign press = deb_q & ~deb_dly_q;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    div_d    = div_q;
    enable_d = 1'b0;
    unique case (state_q)
      ST_STOPPED: begin
        if (press[BTN_RUN]) begin
          state_d = ST_RUNNING;
          pcnt_d  = '0;
          div_d   = div_i;
        end else if (press[BTN_STEP]) begin
          enable_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        // Run press beats the prescaler on the same edge, so stopping never emits a strobe.
        if (press[BTN_RUN]) begin
          state_d = ST_STOPPED;
          pcnt_d  = '0;
        end else if (pcnt_q == div_q) begin
          enable_d = 1'b1;
          pcnt_d   = '0;
          div_d    = div_i;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
    endcase
    running_d = (state_d == ST_RUNNING);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      deb_q     <= '0;
      deb_dly_q <= '0;
      state_q   <= ST_STOPPED;
      pcnt_q    <= '0;
      div_q     <= '0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      div_q     <= div_d;
      enable_q  <= enable_d;
      running_q <= running_d;
    end
  end

  assign enable  = enable_q;
  assign running = running_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Bench for count_enable_gen: directed scenarios plus random button activity, each edge
// compared against an edge-numbered behavioural model of the button/prescale rules.
module tb_count_enable_gen;

  localparam int DIV_W = 16;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int MAXE  = 8191;

  logic             clk = 1'b0;
  logic             reset;
  logic             run_btn;
  logic             step_btn;
  logic [DIV_W-1:0] div_i;
  logic             enable;
  logic             running;

  int checks   = 0;
  int failures = 0;

  // Model: raw samples and debounced levels indexed by edge number since reset release.
  int n;
  bit samp [0:1][0:MAXE];
  bit debm [0:1][0:MAXE];
  int last_chg [0:1];
  bit m_run;
  bit m_en;
  int next_due;

  count_enable_gen #(
    .DIV_W       (DIV_W),
    .SYNC_STAGES (SYNC),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run_btn (run_btn),
    .step_btn(step_btn),
    .div_i   (div_i),
    .enable  (enable),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int b = 0; b < 2; b++) begin
      debm[b][0]  = 1'b0;
      last_chg[b] = 0;
    end
    m_run    = 1'b0;
    m_en     = 1'b0;
    next_due = 0;
  endtask

  // Synchronised level seen just before edge k: the raw sample taken SYNC edges earlier.
  function automatic bit sync_at(input int b, input int k);
    return (k - SYNC >= 1) ? samp[b][k-SYNC] : 1'b0;
  endfunction

  task automatic model_edge(input bit rb, input bit sb, input int dv);
    bit pr [0:1];
    bit chg;
    n++;
    if (n > MAXE) begin
      $display("FAIL model_range: edge %0d beyond model capacity %0d", n, MAXE);
      $fatal(1);
    end
    samp[0][n] = rb;
    samp[1][n] = sb;
    for (int b = 0; b < 2; b++) begin
      pr[b] = debm[b][n-1] & ((n >= 2) ? ~debm[b][n-2] : 1'b1);
      // Level flips once the last DEB synced samples all disagree and it has held that long.
      chg = (n - last_chg[b] >= DEB);
      for (int j = 0; j < DEB; j++)
        if (sync_at(b, n - j) == debm[b][n-1]) chg = 1'b0;
      debm[b][n] = chg ? ~debm[b][n-1] : debm[b][n-1];
      if (chg) last_chg[b] = n;
    end
    if (!m_run) begin
      if (pr[0]) begin
        m_run    = 1'b1;
        m_en     = 1'b0;
        next_due = n + dv + 1;
      end else begin
        m_en = pr[1];
      end
    end else begin
      if (pr[0]) begin
        m_run = 1'b0;
        m_en  = 1'b0;
      end else if (n == next_due) begin
        m_en     = 1'b1;
        next_due = n + dv + 1;
      end else begin
        m_en = 1'b0;
      end
    end
  endtask

  task automatic tick(input bit rb, input bit sb);
    run_btn  = rb;
    step_btn = sb;
    @(posedge clk);
    model_edge(rb, sb, int'(div_i));
    #1;
    check("enable", enable, m_en);
    check("running", running, m_run);
  endtask

  task automatic idle(input int k);
    repeat (k) tick(1'b0, 1'b0);
  endtask

  task automatic wait_strobe(output int gap, input int limit);
    gap = 0;
    do begin
      tick(1'b0, 1'b0);
      gap++;
    end while (!enable && gap < limit);
    check("strobe_wait", enable, 1);
  endtask

  initial begin
    int cnt;
    int gap;
    int q[$];
    int len;
    bit rb;
    bit sb;

    reset    = 1'b0;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    div_i    = 16'd3;
    model_reset();
    #12;
    check("reset_enable", enable, 0);
    check("reset_running", running, 0);
    reset = 1'b1;

    // 1: div=3 -> one strobe every 4 cycles
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0);
      if (i == 6) check("t1_before_entry", running, 0);
      if (i == 7) check("t1_entry_edge7", running, 1);
    end
    cnt = 0;
    repeat (40) begin
      tick(1'b0, 1'b0);
      cnt += int'(enable);
    end
    check("t1_strobes_in_40", cnt, 10);
    check("t1_running", running, 1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    idle(10);

    // 2: bouncing run button, then a clean hold
    for (int i = 0; i < 10; i++) tick(((i % 2) == 0), 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0);
      if (i == 6) check("t2_no_early_run", running, 0);
      if (i == 7) check("t2_run_edge7", running, 1);
    end
    idle(10);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    idle(10);

    // 3: single step while stopped, then step ignored while running
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1);
      cnt += int'(enable);
      if (i == 7) check("t3_step_edge7", enable, 1);
    end
    repeat (12) begin
      tick(1'b0, 1'b0);
      cnt += int'(enable);
    end
    check("t3_one_step_pulse", cnt, 1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    idle(4);
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, (i < 10));
      if (enable) q.push_back(i);
    end
    check("t3_strobe_count", (q.size() >= 5), 1);
    for (int k = 1; k < q.size(); k++) check("t3_spacing", q[k] - q[k-1], 4);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    idle(10);

    // 4: div=0 -> enable held high; stop press drops it on the same edge
    div_i = 16'd0;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    cnt = 0;
    repeat (10) begin
      tick(1'b0, 1'b0);
      cnt += int'(enable);
    end
    check("t4_enable_every_cycle", cnt, 10);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0);
      if (i == 6) check("t4_enable_before_stop", enable, 1);
      if (i == 7) begin
        check("t4_stop_enable", enable, 0);
        check("t4_stop_running", running, 0);
      end
    end
    idle(10);

    // 5: div 7 -> 1 changed mid-period
    div_i = 16'd7;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    wait_strobe(gap, 40);
    idle(2);
    div_i = 16'd1;
    wait_strobe(gap, 40);
    check("t5_current_period", gap + 2, 8);
    wait_strobe(gap, 40);
    check("t5_new_period_a", gap, 2);
    wait_strobe(gap, 40);
    check("t5_new_period_b", gap, 2);

    // 6: async reset mid-RUNNING, then simultaneous run+step
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_enable", enable, 0);
    check("t6_async_running", running, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_held_running", running, 0);
    reset = 1'b1;
    model_reset();
    cnt = 0;
    repeat (20) begin
      tick(1'b0, 1'b0);
      cnt += int'(enable);
    end
    check("t6_no_strobe_after_reset", cnt, 0);
    div_i = 16'd5;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b1);
      cnt += int'(enable);
      if (i == 7) check("t6_run_wins", running, 1);
    end
    repeat (4) begin
      tick(1'b0, 1'b0);
      cnt += int'(enable);
    end
    check("t6_step_dropped", cnt, 0);

    // Random button activity with occasional divisor changes
    repeat (150) begin
      len = $urandom_range(1, 14);
      rb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) div_i = 16'($urandom_range(0, 5));
      repeat (len) tick(rb, sb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
